sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM read master; the requesting end of the system-ID slave interface.
- After reset or on request, reads the ID word (offset 0) and the timestamp word (offset 1) from a sysid slave.
- Compares both words against build-time expected values and reports match, mismatch or timeout.
- Sits beside the boot/housekeeping logic; gates software start or drives a status LED on a bitstream/software mismatch.

Parameters:
- ADDR_W, 4, width of avm_address (word address).
- BASE_ADDR, 0, word address of sysid offset 0; offset 1 is BASE_ADDR+1, modulo 2^ADDR_W.
- EXPECTED_ID, 32'h72A09001, required value of the ID word.
- EXPECTED_TS, 32'h5A3B1C00, required value of the timestamp word.
- CHECK_TS, 1, 1 = read and compare the timestamp; 0 = ID only.
- TIMEOUT, 255, maximum cycles per transaction from first request cycle to readdatavalid; range 1..65535.
- AUTO_START, 1, 1 = start one check automatically after reset release.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  level; sampled only in IDLE or DONE; begins a new check.
- avm_address  out  ADDR_W  word address of the current read.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  check in progress.
- done  out  1  check finished; held until the next start.
- match  out  1  all compared words equal; valid while done=1.
- timeout_err  out  1  a transaction exceeded TIMEOUT; valid while done=1.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word; stays 0 when CHECK_TS=0.

Behaviour:
- Reset: all state updates on the rising clock edge where reset_n=0.
  - State goes to IDLE.
  - avm_read=0, avm_address=BASE_ADDR, busy=0, done=0, match=0, timeout_err=0, id_value=0, ts_value=0, timeout counter=0.
- Reset mid-transaction: the read is abandoned, and any readdatavalid arriving after reset is ignored.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE:
  - Leaves on start=1, or on the first cycle after reset release when AUTO_START=1 (auto-start fires once per reset).
  - Goes to ID_REQ; clears done, match, timeout_err, id_value, ts_value; sets busy=1.
- ID_REQ:
  - avm_read=1, avm_address=BASE_ADDR; both held stable while avm_waitrequest=1.
  - The request is accepted in the cycle with avm_read=1 and avm_waitrequest=0; the next state is ID_WAIT and avm_read drops.
- ID_WAIT:
  - On avm_readdatavalid=1, capture avm_readdata into id_value.
  - Next state is TS_REQ if CHECK_TS=1, otherwise DONE.
- TS_REQ / TS_WAIT: identical to ID_REQ / ID_WAIT, with address BASE_ADDR+1; captured data goes to ts_value; next state is DONE.
- readdatavalid handling:
  - Only sampled in the *_WAIT states.
  - In IDLE, DONE and *_REQ it is ignored.
  - Only one read is ever outstanding.
- Timeout:
  - The counter resets on entry to each *_REQ and increments every cycle in *_REQ and *_WAIT.
  - If the counter reaches TIMEOUT before data is captured: go to DONE, timeout_err=1, match=0, avm_read=0; words already captured are kept.
  - If data capture and counter==TIMEOUT fall in the same cycle, the data wins (no timeout).
- Entering DONE:
  - busy=0 and done=1 are registered on the entry edge.
  - match = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS) && !timeout_err, computed from the captured words.
- DONE: all outputs are held; start=1 re-enters ID_REQ with the same clears as IDLE.
- start while busy is ignored.
- Latency, zero-wait slave with readdatavalid one cycle after acceptance, start sampled at edge 0:
  - avm_read high in cycle 1 (ID) and cycle 3 (TS).
  - done=1 from cycle 5.
  - With CHECK_TS=0, done=1 from cycle 3.

Test Plan:
- AUTO_START=1, slave model returns 32'h72A09001 / 32'h5A3B1C00, no waitrequest, readdatavalid latency 1 -> avm_read in cycles 1 and 3, addresses 0 then 1, done=1 and match=1 from cycle 5, busy low from then.
- Slave returns timestamp 32'h5A3B1C01 -> done=1, match=0, timeout_err=0, ts_value=32'h5A3B1C01.
- waitrequest held for 3 cycles on the ID read -> avm_read and avm_address stable throughout, exactly one accepted read, correct capture; readdatavalid latency 4 also passes.
- TIMEOUT=8, slave never asserts readdatavalid for the TS read -> done=1, timeout_err=1, match=0, id_value retained; a following start with a good slave clears timeout_err and yields match=1.
- reset_n low for 1 cycle while in ID_WAIT, then a stray readdatavalid -> all outputs at reset values, stray data not captured; auto-start reruns the check.
- CHECK_TS=0 with start pulsed in DONE, plus start pulsed while busy -> a single ID-only read, ts_value=0, the busy-time start has no effect.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid ID word (and
// optionally the timestamp word) and compares them with build-time values.
module sysid_checker #(
    parameter int          ADDR_W      = 4,
    parameter int          BASE_ADDR   = 0,
    parameter logic [31:0] EXPECTED_ID = 32'h72A0_9001,
    parameter logic [31:0] EXPECTED_TS = 32'h5A3B_1C00,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int          TIMEOUT     = 255,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              timeout_err,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ID_REQ  = 3'd1;
    localparam logic [2:0] S_ID_WAIT = 3'd2;
    localparam logic [2:0] S_TS_REQ  = 3'd3;
    localparam logic [2:0] S_TS_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] ID_ADDR   = ADDR_W'(BASE_ADDR);
    // Offset 1 wraps modulo 2^ADDR_W through the natural width of the sum.
    localparam logic [ADDR_W-1:0] TS_ADDR   = ID_ADDR + {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       TIMEOUT_C = 16'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              match_q, match_d;
    logic              terr_q, terr_d;
    logic [31:0]       id_q, id_d;
    logic [31:0]       ts_q, ts_d;
    logic              auto_q, auto_d;
    logic              begin_check_s;

    function automatic logic words_match(input logic [31:0] id_w,
                                         input logic [31:0] ts_w,
                                         input logic        terr);
        words_match = (id_w == EXPECTED_ID) &&
                      (!CHECK_TS || (ts_w == EXPECTED_TS)) && !terr;
    endfunction

    // A new check begins on start (IDLE/DONE only) or once after reset release.
    always_comb begin
        begin_check_s = 1'b0;
        if ((state_q == S_IDLE) && (start || auto_q)) begin
            begin_check_s = 1'b1;
        end else if ((state_q == S_DONE) && start) begin
            begin_check_s = 1'b1;
        end else begin
            begin_check_s = 1'b0;
        end
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        read_d  = read_q;
        busy_d  = busy_q;
        done_d  = done_q;
        match_d = match_q;
        terr_d  = terr_q;
        id_d    = id_q;
        ts_d    = ts_q;
        auto_d  = (state_q == S_IDLE) ? 1'b0 : auto_q;

        if (begin_check_s) begin
            state_d = S_ID_REQ;
            cnt_d   = 16'd0;
            addr_d  = ID_ADDR;
            read_d  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            match_d = 1'b0;
            terr_d  = 1'b0;
            id_d    = 32'd0;
            ts_d    = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ID_REQ, S_TS_REQ: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == TIMEOUT_C) begin
                        state_d = S_DONE;
                        read_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        terr_d  = 1'b1;
                        match_d = 1'b0;
                    end else if (!avm_waitrequest) begin
                        state_d = (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
                        read_d  = 1'b0;
                    end else begin
                        read_d  = 1'b1;
                    end
                end
                S_ID_WAIT: begin
                    cnt_d = cnt_q + 16'd1;
                    // Captured data takes priority over a coincident timeout.
                    if (avm_readdatavalid) begin
                        id_d = avm_readdata;
                        if (CHECK_TS) begin
                            state_d = S_TS_REQ;
                            cnt_d   = 16'd0;
                            addr_d  = TS_ADDR;
                            read_d  = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            match_d = words_match(avm_readdata, ts_q, 1'b0);
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = S_DONE;
                        read_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        terr_d  = 1'b1;
                        match_d = 1'b0;
                    end else begin
                        state_d = S_ID_WAIT;
                    end
                end
                S_TS_WAIT: begin
                    cnt_d = cnt_q + 16'd1;
                    if (avm_readdatavalid) begin
                        ts_d    = avm_readdata;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = words_match(id_q, avm_readdata, 1'b0);
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = S_DONE;
                        read_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        terr_d  = 1'b1;
                        match_d = 1'b0;
                    end else begin
                        state_d = S_TS_WAIT;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= ID_ADDR;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            terr_q  <= 1'b0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            terr_q  <= terr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            auto_q  <= auto_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign timeout_err = terr_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule
